// File: rtl/issue_scheduler_if.sv
// Issue scheduler bus: the issue-queue side (master) presents ready entries and
// control, the scheduler side (slave) returns registered grants and FU status.
//   req_valid  entry i ready to issue          req_mem   entry i is a load/store
//   hold       freeze issue this cycle          flush     synchronous pipeline flush
//   gnt_valid  FU f receives an op              gnt_idx   entry index per FU, packed
//   gnt_clr    one-hot OR of granted entries    fu_ready  FU f is free
//   rr_ptr     current round-robin search start
interface issue_scheduler_if #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned NUM_FU  = 3,
    parameter int unsigned IDXW    = $clog2(ENTRIES)
);
    logic [ENTRIES-1:0]     req_valid;
    logic [ENTRIES-1:0]     req_mem;
    logic                   hold;
    logic                   flush;
    logic [NUM_FU-1:0]      gnt_valid;
    logic [NUM_FU*IDXW-1:0] gnt_idx;
    logic [ENTRIES-1:0]     gnt_clr;
    logic [NUM_FU-1:0]      fu_ready;
    logic [IDXW-1:0]        rr_ptr;

    modport master (
        output req_valid, req_mem, hold, flush,
        input  gnt_valid, gnt_idx, gnt_clr, fu_ready, rr_ptr
    );

    modport slave (
        input  req_valid, req_mem, hold, flush,
        output gnt_valid, gnt_idx, gnt_clr, fu_ready, rr_ptr
    );
endinterface

// File: rtl/issue_scheduler.sv
// Round-robin issue scheduler: picks up to NUM_FU eligible issue-queue entries per
// cycle, starting the search at rr_ptr, and hands them to free FUs in ascending
// FU order. Grants are registered (1-cycle latency). Each FU has a busy counter
// loaded with its op latency minus one; fu_ready reflects counter == 0.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   issue_scheduler_if slave modport (requests in, grants/status out)
module issue_scheduler #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned NUM_FU  = 3,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MEM_LAT = 3
) (
    input  logic              clk,
    input  logic              rstn,
    issue_scheduler_if.slave  bus
);
    localparam int unsigned IDXW   = $clog2(ENTRIES);
    localparam int unsigned MaxLat = (MEM_LAT > ALU_LAT) ? MEM_LAT : ALU_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);
    localparam logic [CntW-1:0] AluLoad = CntW'(ALU_LAT - 1);
    localparam logic [CntW-1:0] MemLoad = CntW'(MEM_LAT - 1);

    logic [NUM_FU-1:0]      gnt_valid_q, gnt_valid_d;
    logic [NUM_FU*IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic [ENTRIES-1:0]     gnt_clr_q, gnt_clr_d;
    logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]        busy_q [NUM_FU];
    logic [CntW-1:0]        busy_d [NUM_FU];

    logic [NUM_FU-1:0]      fu_ready;
    logic [ENTRIES-1:0]     elig;

    always_comb begin
        for (int f = 0; f < int'(NUM_FU); f++) begin
            fu_ready[f] = (busy_q[f] == '0);
        end
    end

    // Entries granted last cycle are still VALID in the queue this cycle; mask them.
    assign elig = bus.req_valid & ~gnt_clr_q;

    always_comb begin
        logic [NUM_FU-1:0] avail;
        logic [IDXW-1:0]   idx;
        logic              placed;

        gnt_valid_d = '0;
        gnt_idx_d   = '0;
        gnt_clr_d   = '0;
        rr_ptr_d    = rr_ptr_q;
        avail       = fu_ready;
        idx         = '0;
        placed      = 1'b0;

        for (int f = 0; f < int'(NUM_FU); f++) begin
            busy_d[f] = (busy_q[f] != '0) ? busy_q[f] - CntW'(1) : '0;
        end

        if (!bus.hold) begin
            // Scan order rr_ptr, rr_ptr+1, ...; wrap is free since ENTRIES is 2^IDXW.
            for (int unsigned k = 0; k < ENTRIES; k++) begin
                idx    = rr_ptr_q + IDXW'(k);
                placed = 1'b0;
                if (elig[idx]) begin
                    for (int f = 0; f < int'(NUM_FU); f++) begin
                        if (avail[f] && !placed) begin
                            placed                    = 1'b1;
                            avail[f]                  = 1'b0;
                            gnt_valid_d[f]            = 1'b1;
                            gnt_idx_d[f*IDXW +: IDXW] = idx;
                            gnt_clr_d[idx]            = 1'b1;
                            busy_d[f]                 = bus.req_mem[idx] ? MemLoad : AluLoad;
                            rr_ptr_d                  = idx + IDXW'(1);
                        end
                    end
                end
            end
        end

        if (bus.flush) begin
            gnt_valid_d = '0;
            gnt_idx_d   = '0;
            gnt_clr_d   = '0;
            rr_ptr_d    = '0;
            for (int f = 0; f < int'(NUM_FU); f++) begin
                busy_d[f] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_valid_q <= '0;
            gnt_idx_q   <= '0;
            gnt_clr_q   <= '0;
            rr_ptr_q    <= '0;
            for (int f = 0; f < int'(NUM_FU); f++) begin
                busy_q[f] <= '0;
            end
        end else begin
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_clr_q   <= gnt_clr_d;
            rr_ptr_q    <= rr_ptr_d;
            for (int f = 0; f < int'(NUM_FU); f++) begin
                busy_q[f] <= busy_d[f];
            end
        end
    end

    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_clr   = gnt_clr_q;
    assign bus.fu_ready  = fu_ready;
    assign bus.rr_ptr    = rr_ptr_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboarded directed bench for issue_scheduler (ENTRIES=16, NUM_FU=3,
// ALU_LAT=1, MEM_LAT=3). The driver pushes the hand-computed post-edge response
// of each vector; the monitor pops and compares on the following falling edge.
module tb_issue_scheduler;
    typedef struct {
        int          cyc;
        int          id;
        logic [2:0]  gv;
        logic [11:0] gi;
        logic [15:0] gc;
        logic [2:0]  fr;
        logic [3:0]  rp;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   vec_id = 0;
    exp_t exp_q[$];

    issue_scheduler_if #(.ENTRIES(16), .NUM_FU(3)) bus ();

    issue_scheduler #(
        .ENTRIES(16),
        .NUM_FU (3),
        .ALU_LAT(1),
        .MEM_LAT(3)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Apply one vector for one cycle and queue its expected post-edge response.
    task automatic step(input logic [15:0] rv, input logic [15:0] rm, input logic h,
                        input logic f, input logic [2:0] gv, input logic [11:0] gi,
                        input logic [15:0] gc, input logic [2:0] fr, input logic [3:0] rp);
        exp_t e;
        bus.req_valid = rv;
        bus.req_mem   = rm;
        bus.hold      = h;
        bus.flush     = f;
        vec_id++;
        e.cyc = cyc + 1;
        e.id  = vec_id;
        e.gv  = gv;
        e.gi  = gi;
        e.gc  = gc;
        e.fr  = fr;
        e.rp  = rp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check($sformatf("v%0d timing", e.id), e.cyc, cyc);
            check($sformatf("v%0d gnt_valid", e.id), 32'(bus.gnt_valid), 32'(e.gv));
            check($sformatf("v%0d gnt_idx", e.id), 32'(bus.gnt_idx), 32'(e.gi));
            check($sformatf("v%0d gnt_clr", e.id), 32'(bus.gnt_clr), 32'(e.gc));
            check($sformatf("v%0d fu_ready", e.id), 32'(bus.fu_ready), 32'(e.fr));
            check($sformatf("v%0d rr_ptr", e.id), 32'(bus.rr_ptr), 32'(e.rp));
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, " gnt_valid"}, 32'(bus.gnt_valid), 32'h0);
        check({tag, " gnt_idx"}, 32'(bus.gnt_idx), 32'h0);
        check({tag, " gnt_clr"}, 32'(bus.gnt_clr), 32'h0);
        check({tag, " fu_ready"}, 32'(bus.fu_ready), 32'h7);
        check({tag, " rr_ptr"}, 32'(bus.rr_ptr), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.req_mem   = '0;
        bus.hold      = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check_reset_state("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        //     req_valid  req_mem   h     f     gv      gi        gc        fr      rp
        // Three-wide issue, request held for a second cycle.
        step(16'h00F0, 16'h0000, 1'b0, 1'b0, 3'b111, 12'h654, 16'h0070, 3'b111, 4'd7);
        step(16'h00F0, 16'h0000, 1'b0, 1'b0, 3'b001, 12'h007, 16'h0080, 3'b111, 4'd8);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 12'h000, 16'h0000, 3'b111, 4'd8);
        // Memory op occupies FU0 for three cycles; others go to FU1/FU2.
        step(16'h0001, 16'h0001, 1'b0, 1'b0, 3'b001, 12'h000, 16'h0001, 3'b110, 4'd1);
        step(16'h0006, 16'h0000, 1'b0, 1'b0, 3'b110, 12'h210, 16'h0006, 3'b110, 4'd3);
        step(16'h0008, 16'h0000, 1'b0, 1'b0, 3'b010, 12'h030, 16'h0008, 3'b111, 4'd4);
        step(16'h0010, 16'h0000, 1'b0, 1'b0, 3'b001, 12'h004, 16'h0010, 3'b111, 4'd5);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 12'h000, 16'h0000, 3'b111, 4'd5);
        // Move rr_ptr to 14, then wrap-around grant.
        step(16'h2000, 16'h0000, 1'b0, 1'b0, 3'b001, 12'h00D, 16'h2000, 3'b111, 4'd14);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 12'h000, 16'h0000, 3'b111, 4'd14);
        step(16'hC003, 16'h0000, 1'b0, 1'b0, 3'b111, 12'h0FE, 16'hC001, 3'b111, 4'd1);
        // Hold freezes issue; releasing it issues the next three in order.
        step(16'hFFFF, 16'h0000, 1'b1, 1'b0, 3'b000, 12'h000, 16'h0000, 3'b111, 4'd1);
        step(16'hFFFF, 16'h0000, 1'b0, 1'b0, 3'b111, 12'h321, 16'h000E, 3'b111, 4'd4);
        // Flush (with hold also set) while FU0 is busy on a memory op.
        step(16'h0010, 16'h0010, 1'b0, 1'b0, 3'b001, 12'h004, 16'h0010, 3'b110, 4'd5);
        step(16'h0020, 16'h0000, 1'b1, 1'b1, 3'b000, 12'h000, 16'h0000, 3'b111, 4'd0);
        step(16'h0001, 16'h0000, 1'b0, 1'b0, 3'b001, 12'h000, 16'h0001, 3'b111, 4'd1);
        // Busy counter keeps draining under hold.
        step(16'h0100, 16'h0100, 1'b0, 1'b0, 3'b001, 12'h008, 16'h0100, 3'b110, 4'd9);
        step(16'h0000, 16'h0000, 1'b1, 1'b0, 3'b000, 12'h000, 16'h0000, 3'b110, 4'd9);
        step(16'h0000, 16'h0000, 1'b1, 1'b0, 3'b000, 12'h000, 16'h0000, 3'b111, 4'd9);
        // Memory op in flight, then reset mid-stream.
        step(16'h0200, 16'h0200, 1'b0, 1'b0, 3'b001, 12'h009, 16'h0200, 3'b110, 4'd10);

        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_state("midrst");
        bus.req_valid = 16'hFFFF;
        @(posedge clk);
        #1;
        check("rst_hold gnt_valid", 32'(bus.gnt_valid), 32'h0);
        check("rst_hold gnt_clr", 32'(bus.gnt_clr), 32'h0);
        bus.req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // First grant after reset starts scanning from entry 0.
        step(16'h0400, 16'h0000, 1'b0, 1'b0, 3'b001, 12'h00A, 16'h0400, 3'b111, 4'd11);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 12'h000, 16'h0000, 3'b111, 4'd11);

        repeat (3) @(posedge clk);
        check("drain pending", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of issue-queue entries arbitrated; power of two, 4..64.
REQ-002 SHALL have parameter NUM_FU, default 3: number of ALU functional units.
REQ-003 SHALL have parameter ALU_LAT, default 1: FU occupancy in cycles for a non-memory op, at least 1.
REQ-004 SHALL have parameter MEM_LAT, default 3: FU occupancy in cycles for a load/store op, at least 1.
REQ-005 SHALL define IDXW = log2(ENTRIES) for use in port widths.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 req_valid  input  ENTRIES  entry i is valid, both operands ready, and eligible to issue.
REQ-009 req_mem  input  ENTRIES  entry i is a load/store; ignored where req_valid[i]=0.
REQ-010 hold  input  1  freeze issue: no new grants this cycle.
REQ-011 flush  input  1  synchronous pipeline flush.
REQ-012 gnt_valid  output  NUM_FU  FU f receives an instruction this cycle.
REQ-013 gnt_idx  output  NUM_FU*IDXW  entry index for FU f, packed at bits [f*IDXW +: IDXW].
REQ-014 gnt_clr  output  ENTRIES  one-hot OR of granted entries; the queue clears VALID on it.
REQ-015 fu_ready  output  NUM_FU  FU f is free (busy counter f == 0).
REQ-016 rr_ptr  output  IDXW  current round-robin search start.

Function
REQ-017 SHALL compute eligibility combinationally as req_valid & ~gnt_clr, so entries granted last cycle are never re-granted.
REQ-018 SHALL scan eligible entries in order rr_ptr, rr_ptr+1, ..., wrapping modulo ENTRIES.
REQ-019 SHALL grant min(#eligible, #free FUs) entries; the k-th entry found goes to the k-th free FU in ascending FU index.
REQ-020 SHALL register gnt_valid, gnt_idx and gnt_clr, giving 1-cycle latency from request to grant.
REQ-021 SHALL drive gnt_idx slot f to 0 whenever gnt_valid[f]=0.
REQ-022 SHALL keep a busy counter per FU; on grant it loads (req_mem ? MEM_LAT : ALU_LAT) - 1.
REQ-023 SHALL decrement each nonzero, non-granted busy counter by 1 every cycle, saturating at 0.
REQ-024 SHALL derive fu_ready[f] combinationally as busy counter f == 0; with ALU_LAT=1 an FU accepts back-to-back ops.
REQ-025 SHALL load rr_ptr, when any grant occurs, with (highest-order granted entry in scan order + 1) mod ENTRIES.
REQ-026 SHALL leave rr_ptr unchanged when no grant occurs.
REQ-027 When hold=1, SHALL grant nothing: next-cycle gnt_valid=0 and gnt_clr=0, rr_ptr held, busy counters still decrement.
REQ-028 When flush=1, SHALL override hold; on the next edge it clears gnt_valid, gnt_idx, gnt_clr and all busy counters, and sets rr_ptr=0.
REQ-029 If no FU is free or no entry is eligible, SHALL produce gnt_valid=0 and gnt_clr=0 on the next edge.
REQ-030 SHALL assert at most one grant per entry and one entry per FU each cycle.

Reset
REQ-031 rstn low SHALL immediately force gnt_valid=0, gnt_idx=0, gnt_clr=0, all busy counters 0 (fu_ready all 1), and rr_ptr=0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight grants and busy state with no partial update.
REQ-033 The first grant after rstn deassertion SHALL occur no earlier than the first rising edge with rstn high.

Verification (ENTRIES=16, NUM_FU=3, ALU_LAT=1, MEM_LAT=3)
REQ-034 Reset: pulse rstn low mid-stream -> gnt_valid=000, gnt_clr=0x0000, fu_ready=111, rr_ptr=0.
REQ-035 Three-wide issue: req_valid=0x00F0 (ALU ops) held, rr_ptr=0 -> results over two cycles:
- Cycle 1: gnt_idx={6,5,4} (FU2..FU0), gnt_valid=111, gnt_clr=0x0070, rr_ptr=7.
- Cycle 2: FU0 gets entry 7, gnt_clr=0x0080.
REQ-036 Memory occupancy: req_valid=0x0001, req_mem=0x0001 -> FU0 granted idx 0, fu_ready[0]=0 for the 2 following cycles, then 1; other requests go to FU1/FU2 meanwhile.
REQ-037 Wrap-around: rr_ptr=14, req_valid=0xC003 -> FU0=14, FU1=15, FU2=0, rr_ptr=1.
REQ-038 Hold/flush:
- hold=1 with req_valid=0xFFFF -> no grants, rr_ptr unchanged.
- flush=1 while FU0 is busy (MEM op) -> next cycle fu_ready=111, rr_ptr=0, gnt_valid=000.
